// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational instruction
// memory and queues {pc, word} pairs in a small prefetch buffer for decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_DEPTH = 52,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(BUF_DEPTH);
  localparam logic [29:0]      MEM_WORDS = 30'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } state_t;

  state_t            state, state_next;
  logic [31:0]       pc, pc_next;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  head, tail;
  logic [31:0]       buf_data [BUF_DEPTH];
  logic [31:0]       buf_pc   [BUF_DEPTH];
  logic              pop, push, flush, take_fault, pc_legal, fetch_slot;

  assign imem_addr  = pc;
  assign inst_valid = (count != '0);
  assign inst_data  = buf_data[head];
  assign inst_pc    = buf_pc[head];
  assign fault      = (state == FAULT);

  assign pop        = inst_valid && inst_ready;
  assign pc_legal   = (pc[1:0] == 2'b00) && (pc[31:2] < MEM_WORDS);
  // A full buffer that is being drained this cycle still has room for one word.
  assign fetch_slot = (count < FULL) || pop;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    flush      = 1'b0;
    take_fault = 1'b0;
    if (redirect_valid && state != IDLE) begin
      flush      = 1'b1;
      pc_next    = redirect_pc;
      state_next = RUN;
    end else begin
      case (state)
        IDLE: if (start) state_next = RUN;
        RUN: begin
          if (fetch_slot) begin
            if (pc_legal) begin
              push    = 1'b1;
              pc_next = pc + 32'd4;
            end else begin
              take_fault = 1'b1;
              state_next = FAULT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (take_fault) fault_pc <= pc;
    end
  end

  // NOTE: the buffer storage is reset because the head entry is visible on inst_data/inst_pc straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        buf_data[tail] <= imem_data;
        buf_pc[tail]   <= pc;
        tail           <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a modelled instruction memory and
// hand-computed PC/data sequences for start, backpressure, redirect, fault, reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int n_cmp = 0;
  int n_err = 0;

  fetch_ctrl #(.RESET_PC(32'h0), .MEM_DEPTH(52), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  // Memory model: each word encodes its own word index.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[17:2]};
  endfunction

  assign imem_data = word_at(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    int          n;

    rst_n = 1'b0; start = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;

    // 1: reset values, then streaming with ready held high
    repeat (2) tick();
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_pc", fault_pc, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    start = 1'b1; inst_ready = 1'b1;
    tick();
    start = 1'b0;
    check("t1_not_yet_valid", 32'(inst_valid), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("t1_valid", 32'(inst_valid), 32'd1);
      check("t1_pc", inst_pc, 32'(4 * i));
      check("t1_data", inst_data, word_at(32'(4 * i)));
      tick();
    end

    // 2: backpressure fills the buffer, then release drains with no gaps
    rst_n = 1'b0; #1; tick(); rst_n = 1'b1;
    start = 1'b1; inst_ready = 1'b0;
    repeat (6) tick();
    start = 1'b0;
    check("t2_valid", 32'(inst_valid), 32'd1);
    check("t2_head_pc", inst_pc, 32'h0);
    check("t2_pc_hold", imem_addr, 32'h8);
    inst_ready = 1'b1;
    check("t2_pc0", inst_pc, 32'h0);
    tick();
    check("t2_pc1", inst_pc, 32'h4);
    tick();
    check("t2_pc2", inst_pc, 32'h8);
    check("t2_data2", inst_data, word_at(32'h8));

    // 3: redirect while buffer holds 8,C; concurrent pop is discarded
    inst_ready = 1'b0;
    check("t3_pre_addr", imem_addr, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t3_flushed", 32'(inst_valid), 32'd0);
    check("t3_addr", imem_addr, 32'h40);
    tick();
    check("t3_valid", 32'(inst_valid), 32'd1);
    check("t3_pc", inst_pc, 32'h40);
    check("t3_data", inst_data, word_at(32'h40));

    // 4: run off the end of memory
    exp_pc = 32'h40; last_pc = 32'hFFFF_FFFF; n = 0;
    while (!fault && n < 200) begin
      if (inst_valid) begin
        check("t4_pc", inst_pc, exp_pc);
        check("t4_data", inst_data, word_at(exp_pc));
        last_pc = inst_pc;
        exp_pc  = exp_pc + 32'd4;
      end
      tick();
      n++;
    end
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_last_pc", last_pc, 32'hCC);
    check("t4_fault_pc", fault_pc, 32'hD0);
    check("t4_no_valid", 32'(inst_valid), 32'd0);
    tick(); tick();
    check("t4_still_empty", 32'(inst_valid), 32'd0);
    check("t4_pc_held", imem_addr, 32'hD0);

    // 5: recover from fault by redirect, then fault again on misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    check("t5_fault_clr", 32'(fault), 32'd0);
    check("t5_fault_pc_kept", fault_pc, 32'hD0);
    check("t5_empty", 32'(inst_valid), 32'd0);
    tick();
    check("t5_pc10", inst_pc, 32'h10);
    check("t5_valid", 32'(inst_valid), 32'd1);
    tick();
    check("t5_pc14", inst_pc, 32'h14);
    check("t5_data14", inst_data, word_at(32'h14));
    redirect_valid = 1'b1; redirect_pc = 32'h12;
    tick();
    redirect_valid = 1'b0;
    check("t5_mis_no_fault_yet", 32'(fault), 32'd0);
    check("t5_mis_addr", imem_addr, 32'h12);
    check("t5_mis_empty", 32'(inst_valid), 32'd0);
    tick();
    check("t5_mis_fault", 32'(fault), 32'd1);
    check("t5_mis_fault_pc", fault_pc, 32'h12);
    check("t5_mis_no_valid", 32'(inst_valid), 32'd0);

    // 6: asynchronous reset while faulted and while the buffer is full
    rst_n = 1'b0; #1;
    check("t6_fault_rst", 32'(fault), 32'd0);
    check("t6_fault_pc_rst", fault_pc, 32'h0);
    check("t6_addr_rst", imem_addr, 32'h0);
    tick(); rst_n = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("t6_idle_ignores_redirect", imem_addr, 32'h0);
    start = 1'b1; inst_ready = 1'b0;
    repeat (4) tick();
    check("t6_full_valid", 32'(inst_valid), 32'd1);
    check("t6_full_addr", imem_addr, 32'h8);
    #2 rst_n = 1'b0; #1;
    check("t6_mid_valid", 32'(inst_valid), 32'd0);
    check("t6_mid_inst_pc", inst_pc, 32'h0);
    check("t6_mid_inst_data", inst_data, 32'h0);
    check("t6_mid_addr", imem_addr, 32'h0);
    tick();
    rst_n = 1'b1; inst_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t6_restart_pc0", inst_pc, 32'h0);
    check("t6_restart_data0", inst_data, word_at(32'h0));
    tick();
    check("t6_restart_pc4", inst_pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
